// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the chunked serial adder.
// Optional subtract support is compiled in with the ADDER_SUB_EN macro (see top).
package adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } add_state_t;

   // Number of chunks needed to cover the operand width.
   function automatic int nchunk_of(input int width, input int chunk);
      return width / chunk;
   endfunction

   // Chunk index counter width; never narrower than one bit.
   function automatic int idx_bits(input int nchunk);
      return (nchunk <= 1) ? 1 : $clog2(nchunk);
   endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder slice used once per clock by the
// serial adder. Kept as an explicit ripple so the critical path is exactly
// CHUNK full-adder stages.
module chunk_adder #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co
);

   // Ripple the carry from bit 0 upwards.
   always_comb begin
      logic c;
      s = '0;
      c = ci;
      for (int i = 0; i < CHUNK; i++) begin
         s[i] = x[i] ^ y[i] ^ c;
         c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
      co = c;
   end

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle WIDTH-bit adder that processes CHUNK bits per clock, LSB chunk
// first, with the inter-chunk carry held in a register.
// Macro ADDER_SUB_EN: adds the sub input and overflow output (a - b support).
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | waiting for operands, in_ready high
//   ST_BUSY | adding chunk[idx] each cycle, carry held in carry_reg
//   ST_DONE | result presented, held until out_ready
module chunked_serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry
`ifdef ADDER_SUB_EN
   ,
   output logic             overflow
`endif
);

   localparam int NCHUNK = nchunk_of(WIDTH, CHUNK);
   localparam int IW     = idx_bits(NCHUNK);

   generate
      if ((WIDTH % CHUNK) != 0 || NCHUNK < 1) begin : g_bad_params
         $error("chunked_serial_adder: WIDTH must be a non-zero multiple of CHUNK");
      end
   endgenerate

   add_state_t       state;
   add_state_t       state_nxt;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             carry_reg;
   logic [WIDTH-1:0] sum_r;
   logic             carry_r;
   logic [WIDTH-1:0] b_eff;
   logic             seed;
   logic             last_chunk;
   logic [CHUNK-1:0] x_chunk;
   logic [CHUNK-1:0] y_chunk;
   logic [CHUNK-1:0] s_chunk;
   logic             co_chunk;
`ifdef ADDER_SUB_EN
   logic             overflow_r;
`endif

   assign in_ready   = (state == ST_IDLE) && !rst;
   assign out_valid  = (state == ST_DONE);
   assign last_chunk = (idx == IW'(NCHUNK - 1));
   assign sum        = sum_r;
   assign carry      = carry_r;
`ifdef ADDER_SUB_EN
   assign overflow   = overflow_r;
`endif

   // Effective B operand and carry seed: subtraction is a + ~b + 1.
   always_comb begin
      b_eff = b;
      seed  = cin;
`ifdef ADDER_SUB_EN
      if (sub) begin
         b_eff = ~b;
         seed  = 1'b1;
      end
`endif
   end

   // Select the operand chunk addressed by idx.
   always_comb begin
      x_chunk = '0;
      y_chunk = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         if (idx == IW'(i)) begin
            x_chunk = op_a[i*CHUNK +: CHUNK];
            y_chunk = op_b[i*CHUNK +: CHUNK];
         end
      end
   end

   chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
      .x  (x_chunk),
      .y  (y_chunk),
      .ci (carry_reg),
      .s  (s_chunk),
      .co (co_chunk)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (in_valid && in_ready) state_nxt = ST_BUSY;
         ST_BUSY: if (last_chunk)           state_nxt = ST_DONE;
         ST_DONE: if (out_ready)            state_nxt = ST_IDLE;
         default:                           state_nxt = ST_IDLE;
      endcase
   end

   // Operand capture, chunk-by-chunk accumulation and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx        <= '0;
         op_a       <= '0;
         op_b       <= '0;
         carry_reg  <= 1'b0;
         sum_r      <= '0;
         carry_r    <= 1'b0;
`ifdef ADDER_SUB_EN
         overflow_r <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  op_a      <= a;
                  op_b      <= b_eff;
                  carry_reg <= seed;
                  idx       <= '0;
               end
            end
            ST_BUSY: begin
               for (int i = 0; i < NCHUNK; i++) begin
                  if (idx == IW'(i)) sum_r[i*CHUNK +: CHUNK] <= s_chunk;
               end
               carry_reg <= co_chunk;
               if (last_chunk) begin
                  carry_r    <= co_chunk;
`ifdef ADDER_SUB_EN
                  // Signed overflow: operands agree in sign, result does not.
                  overflow_r <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                                (s_chunk[CHUNK-1] != op_a[WIDTH-1]);
`endif
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Scoreboard bench for chunked_serial_adder: a 16/4 instance for the directed
// cases and an 8/8 instance for the single-chunk back-to-back case.
// Subtract cases are compiled when ADDER_SUB_EN is defined.
module tb_chunked_serial_adder;

   typedef struct packed {
      logic [15:0] s;
      logic        c;
      logic        o;
   } exp16_t;

   typedef struct packed {
      logic [7:0] s;
      logic       c;
      logic       o;
   } exp8_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic        in_valid16 = 1'b0, out_ready16 = 1'b1, cin16 = 1'b0;
   logic        in_ready16, out_valid16, carry16;
   logic [15:0] a16 = '0, b16 = '0, sum16;
   logic        in_valid8 = 1'b0, out_ready8 = 1'b1, cin8 = 1'b0;
   logic        in_ready8, out_valid8, carry8;
   logic [7:0]  a8 = '0, b8 = '0, sum8;
`ifdef ADDER_SUB_EN
   logic        sub16 = 1'b0, sub8 = 1'b0, ovf16, ovf8;
`endif

   exp16_t q16[$];
   exp8_t  q8[$];
   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int last8    = -1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
      .a(a16), .b(b16), .cin(cin16),
`ifdef ADDER_SUB_EN
      .sub(sub16),
`endif
      .out_valid(out_valid16), .out_ready(out_ready16), .sum(sum16), .carry(carry16)
`ifdef ADDER_SUB_EN
      , .overflow(ovf16)
`endif
   );

   chunked_serial_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .cin(cin8),
`ifdef ADDER_SUB_EN
      .sub(sub8),
`endif
      .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8), .carry(carry8)
`ifdef ADDER_SUB_EN
      , .overflow(ovf8)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Full-width golden model for the 8-bit instance.
   function automatic exp8_t model8(input logic [7:0] av, input logic [7:0] bv,
                                    input logic cv, input logic sv);
      logic [7:0] bb;
      logic [8:0] r;
      exp8_t      e;
      bb  = sv ? ~bv : bv;
      r   = {1'b0, av} + {1'b0, bb} + {8'd0, (sv ? 1'b1 : cv)};
      e.s = r[7:0];
      e.c = r[8];
      e.o = (av[7] == bb[7]) && (r[7] != av[7]);
      return e;
   endfunction

   // Monitor for the 16-bit instance: compare on every output handshake.
   always @(negedge clk) begin
      if (out_valid16 && out_ready16) begin
         if (q16.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_out16: out_valid=1 with nothing pending, sum=%0h", sum16);
         end else begin
            exp16_t e;
            e = q16.pop_front();
            check("sum16", 32'(sum16), 32'(e.s));
            check("carry16", 32'(carry16), 32'(e.c));
`ifdef ADDER_SUB_EN
            check("overflow16", 32'(ovf16), 32'(e.o));
`endif
         end
      end
   end

   // Monitor for the 8-bit instance, also checking result spacing.
   always @(negedge clk) begin
      if (out_valid8 && out_ready8) begin
         if (q8.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_out8: out_valid=1 with nothing pending, sum=%0h", sum8);
         end else begin
            exp8_t e;
            e = q8.pop_front();
            check("sum8", 32'(sum8), 32'(e.s));
            check("carry8", 32'(carry8), 32'(e.c));
`ifdef ADDER_SUB_EN
            check("overflow8", 32'(ovf8), 32'(e.o));
`endif
            // IDLE->BUSY->DONE->IDLE, one cycle each, with out_ready high.
            if (last8 >= 0) check("interval8", 32'(cyc - last8), 32'd3);
            last8 = cyc;
         end
      end
   end

   // Offer one operand set to the 16-bit instance; optionally expect a result.
   task automatic send16(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                         input logic sv, input logic [15:0] es, input logic ec,
                         input logic eo, input bit expect_result);
      int guard = 0;
      @(negedge clk);
      while (!in_ready16 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready16) begin
         check("accept16_timeout", 32'd0, 32'd1);
         return;
      end
      a16 = av;
      b16 = bv;
      cin16 = cv;
`ifdef ADDER_SUB_EN
      sub16 = sv;
`endif
      in_valid16 = 1'b1;
      if (expect_result) q16.push_back('{es, ec, eo});
      @(posedge clk);
      #1;
      in_valid16 = 1'b0;
      a16 = 16'hDEAD;
      b16 = 16'hBEEF;
      cin16 = ~cv;
   endtask

   task automatic drain16();
      int guard = 0;
      while (q16.size() != 0 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (q16.size() != 0) check("drain16_timeout", 32'(q16.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      exp8_t e8;
      logic [7:0] va, vb;
      logic vc, vs;

      // 1. Reset held two cycles, then released.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready16), 32'd0);
      check("rst_out_valid", 32'(out_valid16), 32'd0);
      check("rst_sum", 32'(sum16), 32'd0);
      check("rst_carry", 32'(carry16), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", 32'(in_ready16), 32'd1);

      // 2. Carry ripples through every chunk; out_valid after 4 edges.
      send16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         check("latency16", 32'(out_valid16), 32'(k == 5));
      end
      drain16();

      // 3. Backpressure: result held while out_ready is low.
      out_ready16 = 1'b0;
      send16(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b1);
      guard = 0;
      while (!out_valid16 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("hold_valid", 32'(out_valid16), 32'd1);
         check("hold_sum", 32'(sum16), 32'h5556);
         check("hold_carry", 32'(carry16), 32'd0);
      end
      @(posedge clk);
      #1;
      out_ready16 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("release_valid", 32'(out_valid16), 32'd0);
      check("release_in_ready", 32'(in_ready16), 32'd1);
      drain16();

      // A few more unsigned additions.
      send16(16'h00F0, 16'h0F10, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0, 1'b1);
      drain16();
      send16(16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b1);
      drain16();

      // 4. Reset two BUSY cycles into an operation discards it.
      send16(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_sum", 32'(sum16), 32'd0);
      check("abort_carry", 32'(carry16), 32'd0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("abort_no_valid", 32'(out_valid16), 32'd0);
      end
      send16(16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b1);
      drain16();

`ifdef ADDER_SUB_EN
      // 5. Subtraction and signed overflow.
      send16(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);
      drain16();
      send16(16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
      drain16();
      sub16 = 1'b0;
`endif

      // 6. Single-chunk instance, in_valid and out_ready held high.
      for (int n = 0; n < 24; n++) begin
         @(negedge clk);
         guard = 0;
         while (!in_ready8 && guard < 20) begin
            @(negedge clk);
            guard++;
         end
         if (!in_ready8) begin
            check("accept8_timeout", 32'd0, 32'd1);
            break;
         end
         vs = 1'b0;
         if (n == 0) begin
            va = 8'h80; vb = 8'h80; vc = 1'b0;
         end else if (n == 1) begin
            va = 8'hFF; vb = 8'h00; vc = 1'b1;
         end else begin
            va = 8'($urandom_range(0, 255));
            vb = 8'($urandom_range(0, 255));
            vc = 1'($urandom_range(0, 1));
`ifdef ADDER_SUB_EN
            vs = 1'($urandom_range(0, 1));
`endif
         end
         a8 = va;
         b8 = vb;
         cin8 = vc;
`ifdef ADDER_SUB_EN
         sub8 = vs;
`endif
         in_valid8 = 1'b1;
         if (n == 0) q8.push_back('{8'h00, 1'b1, 1'b1});
         else if (n == 1) q8.push_back('{8'h00, 1'b1, 1'b0});
         else begin
            e8 = model8(va, vb, vc, vs);
            q8.push_back(e8);
         end
      end
      @(negedge clk);
      in_valid8 = 1'b0;
      guard = 0;
      while (q8.size() != 0 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("drain8", 32'(q8.size()), 32'd0);
      check("drain16_final", 32'(q16.size()), 32'd0);

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
